opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
Multi-register OPB slave giving the PowerPC a bank of C_NUM_REGS 32-bit control words, all presented in parallel to user (Simulink) logic. It replaces per-register single-word slaves (start, reset, config) with one decoded bank. Each register can be a level register or a self-clearing pulse register. Each register has its own write strobe, and read-back works across the whole bank.

Parameters:
C_BASEADDR, 32'h010B2100, bank base address (word-aligned).
C_HIGHADDR, 32'h010B21FF, bank top address; decode window is [C_BASEADDR, C_HIGHADDR].
C_OPB_AWIDTH, 32, OPB address width (fixed 32).
C_OPB_DWIDTH, 32, OPB data width (fixed 32).
C_NUM_REGS, 4, register count, legal range 1..64; must fit the window.
C_PULSE_MASK, 0, bit i=1 makes register i self-clearing (pulse mode).
C_FAMILY, "virtex5", target family; informational only.

Ports:
OPB_Clk  in  1  single clock for bus and user side.
OPB_Rst  in  1  synchronous, active-high reset.
OPB_ABus  in  [0:31]  address.
OPB_BE  in  [0:3]  byte enables; BE[0] maps to DBus[0:7] (MSB byte).
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1=read, 0=write.
OPB_select  in  1  slave select.
OPB_seqAddr  in  1  sequential-address hint.
Sl_DBus  out  [0:31]  read data; zero except in ACK.
Sl_errAck  out  1  error acknowledge.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
Sl_xferAck  out  1  transfer acknowledge.
user_data_out  out  [C_NUM_REGS*32-1:0]  register i is at bits [32*i+31:32*i]; OPB bit 0 maps to user bit 31.
user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per register write.

Behaviour:
- Reset: synchronous on OPB_Rst. FSM goes to IDLE. All registers, user_wr_strobe, Sl_DBus, Sl_xferAck and Sl_errAck go to 0. Reset overrides an in-flight transfer; no ack is issued for it.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Index: (OPB_ABus - C_BASEADDR) >> 2. Index >= C_NUM_REGS is out of range.
- The hit, index, RNW, BE and DBus are captured in IDLE on the hit cycle.
- IDLE: on hit, go to ACK next cycle. Latency is select-to-xferAck = 1 cycle.
- ACK (exactly one cycle):
  - Sl_xferAck=1.
  - Read, in range: Sl_DBus = stored register value.
  - Read, out of range: Sl_DBus = 0 and Sl_errAck=1.
  - Write, in range: bytes with BE set are updated at the end of ACK; bytes with BE clear keep their value. user_wr_strobe[i]=1 in the cycle after ACK, the same cycle the new value appears on user_data_out.
  - Write, out of range: no register change and Sl_errAck=1.
  - Always go to HOLD next.
- HOLD: outputs idle. Go to IDLE when OPB_select=0 or OPB_seqAddr=1. A new hit is never acked without passing through IDLE, so there is never a double ack.
- Pulse registers (C_PULSE_MASK[i]=1):
  - The written value is visible on user_data_out for exactly one cycle (the strobe cycle), then the register clears to 0.
  - A read returns 0 unless the read ACK coincides with the visible cycle.
- Write during the pulse-visible cycle: the new write takes priority over the clear.
- Sl_retry and Sl_toutSup are constant 0.

Optional Feature:
Macro OPB_REG_STATUS_READ_EN.
- Defined:
  - Adds input user_data_in [C_NUM_REGS*32-1:0].
  - In-range reads return the user_data_in slice sampled at the IDLE hit cycle, instead of the stored value.
  - Writes and user_data_out are unchanged.
- Undefined: the port is absent and reads return stored values.

Test Plan:
- Reset, then read index 0..3 -> each read acks 1 cycle after select; Sl_DBus=0; Sl_errAck=0.
- Write 0xDEADBEEF to C_BASEADDR+0x8 with BE=4'b1111 -> user_data_out[95:64]=0xDEADBEEF and user_wr_strobe=4'b0100 for one cycle; a read of +0x8 returns 0xDEADBEEF.
- Write 0x11223344 to index 1 with BE=4'b0101, prior value 0xAAAAAAAA -> register becomes 0xAA22AA44.
- C_PULSE_MASK=4'b0001; write 0x1 to index 0 -> user_data_out[31:0]=1 for exactly one cycle, then 0.
- Read C_BASEADDR+0x10 with C_NUM_REGS=4 -> Sl_xferAck=1, Sl_errAck=1, Sl_DBus=0, no register changes.
- Assert OPB_Rst during the ACK of a write to index 2 -> no ack is issued, register 2=0, no strobe, FSM returns to IDLE.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: OPB slave exposing C_NUM_REGS 32-bit level/pulse registers to user logic.
// Optional macro OPB_REG_STATUS_READ_EN: reads return sampled user_data_in instead of stored values.
`default_nettype none

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B21FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'd0,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_wr_strobe
`ifdef OPB_REG_STATUS_READ_EN
  ,
  input  logic [C_NUM_REGS*32-1:0] user_data_in
`endif
);

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  generate
    if ((C_OPB_AWIDTH != 32) || (C_OPB_DWIDTH != 32) || (C_NUM_REGS < 1) || (C_NUM_REGS > 64) ||
        (C_HIGHADDR < C_BASEADDR) || (C_BASEADDR[1:0] != 2'b00) ||
        (((C_HIGHADDR - C_BASEADDR) >> 2) < 32'(C_NUM_REGS - 1))) begin : g_param_check
      $error("opb_register_bank_ppc2simulink: illegal parameter set for family %s", C_FAMILY);
    end
  endgenerate

  state_t                   r_state, w_next;
  logic [C_NUM_REGS*32-1:0] r_data;
  logic [C_NUM_REGS-1:0]    r_strobe;
  logic [IW-1:0]            r_idx;
  logic                     r_rnw;
  logic                     r_in_range;
  logic [3:0]               r_be;
  logic [31:0]              r_wdata;
  logic [31:0]              w_offset;
  logic [31:0]              w_idx_full;
  logic                     w_hit;
  logic                     w_in_range;
  logic                     w_ack;
  logic [31:0]              w_rd;

  assign w_offset   = OPB_ABus - C_BASEADDR;
  assign w_idx_full = w_offset >> 2;
  assign w_hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_in_range = w_idx_full < 32'(C_NUM_REGS);

  // Reset wins over the ACK cycle: a transfer interrupted by reset is never acknowledged.
  assign w_ack = (r_state == ACK) && !OPB_Rst;

`ifdef OPB_REG_STATUS_READ_EN
  logic [31:0] r_status;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_status <= '0;
    end else if ((r_state == IDLE) && w_hit) begin
      r_status <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (w_idx_full == 32'(i)) r_status <= user_data_in[32*i +: 32];
      end
    end
  end

  assign w_rd = r_status;
`else
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (r_idx == IW'(i)) w_rd = r_data[32*i +: 32];
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_next = ACK;
      ACK:     w_next = HOLD;
      HOLD:    if (!OPB_select || OPB_seqAddr) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_strobe   <= '0;
      r_idx      <= '0;
      r_rnw      <= 1'b0;
      r_in_range <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else begin
      r_state  <= w_next;
      r_strobe <= '0;
      if ((r_state == IDLE) && w_hit) begin
        r_idx      <= w_idx_full[IW-1:0];
        r_rnw      <= OPB_RNW;
        r_in_range <= w_in_range;
        r_be       <= OPB_BE;
        r_wdata    <= OPB_DBus;
      end
      // Pulse registers clear after their strobe cycle; a write landing on the same edge wins.
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_PULSE_MASK[i] && r_strobe[i]) r_data[32*i +: 32] <= '0;
        if ((r_state == ACK) && !r_rnw && r_in_range && (r_idx == IW'(i))) begin
          for (int k = 0; k < 4; k++) begin
            if (r_be[k]) r_data[32*i + 8*k +: 8] <= r_wdata[8*k +: 8];
          end
          r_strobe[i] <= 1'b1;
        end
      end
    end
  end

  assign Sl_xferAck     = w_ack;
  assign Sl_errAck      = w_ack && !r_in_range;
  assign Sl_DBus        = (w_ack && r_rnw && r_in_range) ? w_rd : 32'd0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_data_out  = r_data;
  assign user_wr_strobe = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed self-checking bench for opb_register_bank_ppc2simulink (register 0 configured as pulse).
`default_nettype none

module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h010B2100;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         sl_err;
  logic         sl_retry;
  logic         sl_tout;
  logic         sl_ack;
  logic [127:0] udo;
  logic [3:0]   ustb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (32'h010B21FF),
    .C_NUM_REGS  (4),
    .C_PULSE_MASK(64'h1)
  ) dut (
`ifdef OPB_REG_STATUS_READ_EN
    .user_data_in  (128'd0),
`endif
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .Sl_xferAck    (sl_ack),
    .user_data_out (udo),
    .user_wr_strobe(ustb)
  );

  // One OPB transfer; returns in the cycle after ACK (the strobe cycle) with select dropped.
  task automatic bus(input logic [31:0] addr, input logic r, input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    abus = addr; rnw = r; be = b; dbus = d; sel = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (sl_ack === 1'b1) begin
        lat = c; rd = sl_dbus; err = sl_err;
        break;
      end
    end
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0; abus = '0;
    total++;
    if (sl_ack !== 1'b0) begin bad++; $display("FAIL no_double_ack: got %b want 0", sl_ack); end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int lat;
    rst = 1'b1; sel = 1'b0; seq = 1'b0; rnw = 1'b1; be = '0; dbus = '0; abus = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sl_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", sl_ack); end
    total++; if (sl_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", sl_err); end
    total++; if (sl_dbus !== 32'd0) begin bad++; $display("FAIL reset_dbus: got %h want 0", sl_dbus); end
    total++; if (udo !== 128'd0) begin bad++; $display("FAIL reset_udo: got %h want 0", udo); end
    total++; if (ustb !== 4'd0) begin bad++; $display("FAIL reset_strobe: got %b want 0", ustb); end
    total++; if ({sl_retry, sl_tout} !== 2'b00) begin bad++; $display("FAIL tied_low: got %b want 00", {sl_retry, sl_tout}); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(BASE + 32'(4 * i), 1'b1, 4'h0, 32'd0, rd, err, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL reset_read_lat[%0d]: got %0d want 1", i, lat); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_read_data[%0d]: got %h want 0", i, rd); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_read_err[%0d]: got %b want 0", i, err); end
    end
  endtask

  task automatic test_write_full();
    logic [31:0] rd; logic err; int lat;
    bus(BASE + 32'h8, 1'b0, 4'hF, 32'hDEADBEEF, rd, err, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL wr2_lat: got %0d want 1", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr2_err: got %b want 0", err); end
    total++; if (udo[95:64] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr2_udo: got %h want deadbeef", udo[95:64]); end
    total++; if (ustb !== 4'b0100) begin bad++; $display("FAIL wr2_strobe: got %b want 0100", ustb); end
    @(posedge clk); #1;
    total++; if (ustb !== 4'b0000) begin bad++; $display("FAIL wr2_strobe_len: got %b want 0000", ustb); end
    total++; if (udo[95:64] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr2_level_hold: got %h want deadbeef", udo[95:64]); end
    bus(BASE + 32'h8, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd2_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic err; int lat;
    bus(BASE + 32'h4, 1'b0, 4'hF, 32'hAAAAAAAA, rd, err, lat);
    bus(BASE + 32'h4, 1'b0, 4'b0101, 32'h11223344, rd, err, lat);
    total++; if (udo[63:32] !== 32'hAA22AA44) begin bad++; $display("FAIL be_udo: got %h want aa22aa44", udo[63:32]); end
    total++; if (ustb !== 4'b0010) begin bad++; $display("FAIL be_strobe: got %b want 0010", ustb); end
    bus(BASE + 32'h4, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (rd !== 32'hAA22AA44) begin bad++; $display("FAIL be_read: got %h want aa22aa44", rd); end
  endtask

  task automatic test_pulse();
    logic [31:0] rd; logic err; int lat;
    bus(BASE, 1'b0, 4'hF, 32'h1, rd, err, lat);
    total++; if (udo[31:0] !== 32'h1) begin bad++; $display("FAIL pulse_visible: got %h want 1", udo[31:0]); end
    total++; if (ustb !== 4'b0001) begin bad++; $display("FAIL pulse_strobe: got %b want 0001", ustb); end
    @(posedge clk); #1;
    total++; if (udo[31:0] !== 32'h0) begin bad++; $display("FAIL pulse_clear: got %h want 0", udo[31:0]); end
    bus(BASE, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL pulse_read: got %h want 0", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int lat;
    logic [127:0] expv;
    expv = {32'h0, 32'hDEADBEEF, 32'hAA22AA44, 32'h0};
    bus(BASE + 32'hC, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_idx_err: got %b want 0", err); end
    bus(BASE + 32'h10, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL oor_rd_lat: got %0d want 1", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b want 1", err); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    bus(BASE + 32'hFC, 1'b0, 4'hF, 32'hFFFFFFFF, rd, err, lat);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", err); end
    total++; if (ustb !== 4'b0000) begin bad++; $display("FAIL oor_wr_strobe: got %b want 0000", ustb); end
    total++; if (udo !== expv) begin bad++; $display("FAIL oor_wr_regs: got %h want %h", udo, expv); end
    bus(BASE + 32'h100, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL miss_no_ack: got lat %0d want none", lat); end
    bus(BASE - 32'h4, 1'b0, 4'hF, 32'hFFFFFFFF, rd, err, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL below_base_no_ack: got lat %0d want none", lat); end
  endtask

  task automatic test_reset_during_ack();
    logic [31:0] rd; logic err; int lat;
    @(posedge clk); #1;
    abus = BASE + 32'h8; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678; sel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (sl_ack !== 1'b0) begin bad++; $display("FAIL rst_ack_suppressed: got %b want 0", sl_ack); end
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0; abus = '0;
    total++; if (udo[95:64] !== 32'd0) begin bad++; $display("FAIL rst_reg2: got %h want 0", udo[95:64]); end
    total++; if (ustb !== 4'b0000) begin bad++; $display("FAIL rst_no_strobe: got %b want 0000", ustb); end
    total++; if (sl_ack !== 1'b0) begin bad++; $display("FAIL rst_late_ack: got %b want 0", sl_ack); end
    bus(BASE + 32'h8, 1'b1, 4'h0, 32'd0, rd, err, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL rst_idle_lat: got %0d want 1", lat); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_read_reg2: got %h want 0", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_full();
    test_byte_enable();
    test_pulse();
    test_out_of_range();
    test_reset_during_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
